// File: rtl/ahb_modport.sv
// AHB-Lite single-slave word RAM endpoint with byte-lane writes and a two-cycle ERROR response.
// Optional data-phase wait states are enabled by defining AHB_MODPORT_WAIT_EN.
module ahb_modport #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int HRESP_W     = 2,
  parameter int WAIT_STATES = 2
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [3:0]         HPROT,
  input  logic               HREADY,
  input  logic [DATA_W-1:0]  HWDATA,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               HREADYOUT,
  output logic [HRESP_W-1:0] HRESP
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AQ_W  = OFF_W + IDX_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BYTES);
`ifdef AHB_MODPORT_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t            state_q;
  logic              hreadyout_q;
  logic              hresp_q;
  logic [AQ_W-1:0]   addr_q;
  logic              write_q;
  logic [2:0]        size_q;
`ifdef AHB_MODPORT_WAIT_EN
  logic [CNT_W-1:0]  cnt_q;
`endif
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_s;
  logic              err_s;
  logic              we_s;
  logic [IDX_W-1:0]  idx_s;
  logic [BYTES-1:0]  wmask_s;
  logic              unused_ok;

  // Byte lanes [off .. off+2**size-1] of the word, little-endian
  function automatic logic [BYTES-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [2:0] size);
    logic [BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(off)) && (b < int'(off) + (32'sd1 <<< size))) m[b] = 1'b1;
      else m[b] = 1'b0;
    end
    return m;
  endfunction

  assign acc_s = HSEL & HREADY & HTRANS[1];
  assign err_s = ({1'b0, HADDR} >= LIMIT) || (HSIZE > 3'(OFF_W)) ||
                 ((HADDR & ~({ADDR_W{1'b1}} << HSIZE)) != '0);
  assign idx_s   = addr_q[AQ_W-1:OFF_W];
  assign wmask_s = lane_mask(addr_q[OFF_W-1:0], size_q);
  assign we_s    = HRESETn & (state_q == ST_DATA) & write_q;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0], (WAIT_STATES > 0)};

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = {{(HRESP_W-1){1'b0}}, hresp_q};

  // Read data is only driven during an OKAY read data phase
  always_comb begin
    HRDATA = '0;
    if ((state_q == ST_DATA) && !write_q) HRDATA = mem_q[idx_s];
    else HRDATA = '0;
  end

  // Transfer FSM: address-phase sampling, wait/error sequencing and response outputs
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
`ifdef AHB_MODPORT_WAIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
`ifdef AHB_MODPORT_WAIT_EN
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        // IDLE, DATA completion and ERR2 all leave HREADY high, so a new address phase can land
        default: begin
          if (acc_s) begin
            addr_q  <= HADDR[AQ_W-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (err_s) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              hresp_q <= 1'b0;
`ifdef AHB_MODPORT_WAIT_EN
              if (WAIT_STATES > 0) begin
                state_q     <= ST_WAIT;
                hreadyout_q <= 1'b0;
                cnt_q       <= CNT_W'(WAIT_STATES - 1);
              end else begin
                state_q     <= ST_DATA;
                hreadyout_q <= 1'b1;
              end
`else
              state_q     <= ST_DATA;
              hreadyout_q <= 1'b1;
`endif
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // RAM byte-lane write at the end of an OKAY write data phase; contents survive reset
  always_ff @(posedge HCLK) begin
    if (we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask_s[b]) mem_q[idx_s][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_modport.sv
// Directed self-checking bench for ahb_modport (DATA_W=32, DEPTH=256); HREADY is tied to HREADYOUT.
module tb_ahb_modport;

`ifdef AHB_MODPORT_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  int checks = 0;
  int errors = 0;

  ahb_modport #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .HRESP_W(2), .WAIT_STATES(2)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HREADY(hready),
    .HWDATA(hwdata), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp)
  );

  assign hready = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0;
  endtask

  // Wait at negedges until HREADYOUT is high; returns low-cycle count and HRESP seen while low
  task automatic wait_ready(output int lows, output logic [1:0] resp_low);
    lows = 0;
    resp_low = 2'b00;
    while (hreadyout !== 1'b1 && lows < 20) begin
      if (lows == 0) resp_low = hresp;
      lows++;
      @(negedge hclk);
    end
    if (lows >= 20) check("ready_timeout", 32'(lows), 32'd0);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int lows, output logic [1:0] resp_low,
                      output logic [1:0] resp_done);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'd2; hwrite = wr; hsize = sz; haddr = a;
    @(posedge hclk);
    @(negedge hclk);
    bus_idle();
    hwdata = wd;
    wait_ready(lows, resp_low);
    rd = hrdata;
    resp_done = hresp;
    @(posedge hclk);
  endtask

  logic [31:0] rd;
  int          lows;
  logic [1:0]  rlow;
  logic [1:0]  rdone;

  initial begin
    hresetn = 1'b0; hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
    bus_idle();
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    hresetn = 1'b1;

    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, lows, rlow, rdone);
    check("wr10_wait", 32'(lows), 32'(EXP_WAIT));
    check("wr10_resp", 32'(rdone), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("rd10_data", rd, 32'hDEADBEEF);
    check("rd10_resp", 32'(rdone), 32'd0);
    check("rd10_wait", 32'(lows), 32'(EXP_WAIT));

    xfer(1'b1, 32'h10, 3'd2, 32'h11223344, rd, lows, rlow, rdone);
    xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, rd, lows, rlow, rdone);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("byte_wr13", rd, 32'hAA223344);

    xfer(1'b1, 32'h12, 3'd1, 32'h55660000, rd, lows, rlow, rdone);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("half_wr12", rd, 32'h55663344);

    xfer(1'b1, 32'h11, 3'd0, 32'h0000EE00, rd, lows, rlow, rdone);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("byte_wr11", rd, 32'h5566EE44);

    xfer(1'b0, 32'h400, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("oor_lowcycles", 32'(lows), 32'd1);
    check("oor_resp1", 32'(rlow), 32'd1);
    check("oor_resp2", 32'(rdone), 32'd1);
    check("oor_hrdata", rd, 32'h0);

    xfer(1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd, lows, rlow, rdone);
    xfer(1'b1, 32'h2, 3'd2, 32'hFFFFFFFF, rd, lows, rlow, rdone);
    check("misal_lowcycles", 32'(lows), 32'd1);
    check("misal_resp1", 32'(rlow), 32'd1);
    check("misal_resp2", 32'(rdone), 32'd1);
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("misal_nowrite", rd, 32'hCAFEF00D);

    xfer(1'b1, 32'h8, 3'd3, 32'h0, rd, lows, rlow, rdone);
    check("oversize_resp", 32'(rdone), 32'd1);

    xfer(1'b1, 32'h3FC, 3'd2, 32'h0BADF00D, rd, lows, rlow, rdone);
    check("last_wr_resp", 32'(rdone), 32'd0);
    xfer(1'b0, 32'h3FC, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("last_rd", rd, 32'h0BADF00D);

    // Back-to-back: read address phase overlaps the write data phase to the same word
    xfer(1'b1, 32'h20, 3'd2, 32'h0, rd, lows, rlow, rdone);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
    @(posedge hclk);
    @(negedge hclk);
    hwdata = 32'h12345678;
    hwrite = 1'b0;
    wait_ready(lows, rlow);
    @(posedge hclk);
    @(negedge hclk);
    bus_idle();
    wait_ready(lows, rlow);
    check("b2b_rd", hrdata, 32'h12345678);
    check("b2b_resp", 32'(hresp), 32'd0);
    @(posedge hclk);

    @(negedge hclk);
    hsel = 1'b0; htrans = 2'd2; haddr = 32'h10;
    @(posedge hclk);
    @(negedge hclk);
    check("nosel_ready", 32'(hreadyout), 32'd1);
    check("nosel_hrdata", hrdata, 32'h0);
    hsel = 1'b1; htrans = 2'd1;
    @(posedge hclk);
    @(negedge hclk);
    check("busy_ready", 32'(hreadyout), 32'd1);
    check("busy_resp", 32'(hresp), 32'd0);
    check("busy_hrdata", hrdata, 32'h0);
    bus_idle();

    // Reset during the write data phase abandons the write
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    @(posedge hclk);
    @(negedge hclk);
    bus_idle();
    hwdata = 32'h99999999;
    hresetn = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    check("midrst_ready", 32'(hreadyout), 32'd1);
    check("midrst_resp", 32'(hresp), 32'd0);
    hresetn = 1'b1;
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rlow, rdone);
    check("midrst_nowrite", rd, 32'h5566EE44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
